// File: rtl/bus_pkg.sv
// Shared types and constants for the byte-serial CPU bus responder.
package bus_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, TURN, DATA} state_t;

    localparam int   BEATS    = 4;
    localparam int   BYTE_W   = 8;
    localparam logic RW_WRITE = 1'b1;

    function automatic logic [BYTE_W-1:0] get_byte(input logic [BEATS*BYTE_W-1:0] w, input int k);
        return BYTE_W'(w >> (k * BYTE_W));
    endfunction
endpackage

// File: rtl/bus_mem_responder_if.sv
// Byte-serial CPU bus: initiator drives frames, responder returns read bytes.
interface bus_mem_responder_if;
    logic       bus_start;
    logic       bus_rw;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_rdata_oe;

    modport master (output bus_start, bus_rw, bus_addr, bus_wdata,
                    input  bus_rdata, bus_rdata_oe);
    modport slave  (input  bus_start, bus_rw, bus_addr, bus_wdata,
                    output bus_rdata, bus_rdata_oe);
endinterface

// File: rtl/bus_beat_counter.sv
// Phase down-counter: load a phase length, count to zero, flag the final cycle.
module bus_beat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic [W-1:0] cnt,
    output logic         last
);
    always_ff @(posedge clk) begin
        if (rst)            cnt <= '0;
        else if (load)      cnt <= len - W'(1);
        else if (cnt != '0) cnt <= cnt - W'(1);
    end

    assign last = (cnt == '0);
endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder: turns byte-serial bus frames into single-cycle
// parallel memory requests and serialises read data back onto the bus.
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter int GAP   = 2,
    parameter int BEATS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_mem_responder_if.slave   bus,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 mem_we,
    output logic                 mem_re,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_rvalid,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err_late
);
    localparam int CNT_W = $clog2(((GAP > BEATS) ? GAP : BEATS) + 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_len;
    logic             cnt_load, last;
    logic             rw_q, got_q, rd_frame;
    logic [31:0]      rbuf;
    int               addr_k;

    bus_beat_counter #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .len  (cnt_len),
        .cnt  (cnt),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // A new frame start wins over every phase transition.
    always_comb begin
        state_nx = state;
        if (bus.bus_start) state_nx = ADDR;
        else begin
            case (state)
                ADDR:    if (last) state_nx = TURN;
                TURN:    if (last) state_nx = DATA;
                DATA:    if (last) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        rd_frame = (rw_q != RW_WRITE);
        addr_k   = BEATS - 1 - int'(cnt);
        cnt_load = 1'b0;
        cnt_len  = '0;
        if (bus.bus_start) begin
            cnt_load = 1'b1;
            cnt_len  = CNT_W'(BEATS);
        end else if (last && state == ADDR) begin
            cnt_load = 1'b1;
            cnt_len  = CNT_W'(GAP);
        end else if (last && state == TURN) begin
            cnt_load = 1'b1;
            cnt_len  = CNT_W'(BEATS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr         <= '0;
            mem_wdata        <= '0;
            mem_we           <= 1'b0;
            mem_re           <= 1'b0;
            frame_done       <= 1'b0;
            err_late         <= 1'b0;
            bus.bus_rdata    <= '0;
            bus.bus_rdata_oe <= 1'b0;
            rw_q             <= 1'b0;
            got_q            <= 1'b0;
            rbuf             <= '0;
        end else begin
            mem_we           <= 1'b0;
            mem_re           <= 1'b0;
            frame_done       <= 1'b0;
            bus.bus_rdata    <= '0;
            bus.bus_rdata_oe <= 1'b0;
            case (state)
                ADDR: begin
                    for (int i = 0; i < BEATS; i++) begin
                        if (i == addr_k) begin
                            mem_addr[i*BYTE_W +: BYTE_W]  <= bus.bus_addr;
                            mem_wdata[i*BYTE_W +: BYTE_W] <= bus.bus_wdata;
                        end
                    end
                    if (addr_k == 0) rw_q <= bus.bus_rw;
                    if (last && !bus.bus_start) begin
                        mem_we <= (rw_q == RW_WRITE);
                        mem_re <= (rw_q != RW_WRITE);
                    end
                end
                TURN: begin
                    if (rd_frame && mem_rvalid && !got_q) begin
                        rbuf  <= mem_rdata;
                        got_q <= 1'b1;
                    end
                    // Strobe in the final turnaround cycle bypasses rbuf for byte 0.
                    if (last && !bus.bus_start && rd_frame) begin
                        bus.bus_rdata_oe <= 1'b1;
                        if (got_q)           bus.bus_rdata <= get_byte(rbuf, 0);
                        else if (mem_rvalid) bus.bus_rdata <= mem_rdata[BYTE_W-1:0];
                        else                 err_late      <= 1'b1;
                    end
                end
                DATA: begin
                    if (last) frame_done <= 1'b1;
                    else if (!bus.bus_start && rd_frame) begin
                        bus.bus_rdata_oe <= 1'b1;
                        if (got_q) bus.bus_rdata <= get_byte(rbuf, BEATS - int'(cnt));
                    end
                end
                default: ;
            endcase
            if (bus.bus_start) got_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: table of whole frames plus abort/back-to-back/reset sequences.
module tb_bus_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re, mem_rvalid, busy, frame_done, err_late;

    bus_mem_responder_if bif();

    bus_mem_responder #(.GAP(2), .BEATS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bif),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .busy       (busy),
        .frame_done (frame_done),
        .err_late   (err_late)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // rv bits: [0] strobe in TURN0 with rd0, [1] strobe in TURN1 with rd1, [2] strobe during DATA with rd1
    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [2:0]  rv;
        logic        exp_we;
        logic        exp_re;
        logic        exp_oe;
        logic [31:0] exp_word;
        logic        exp_err;
    } vec_t;

    vec_t vt[8];
    vec_t vx;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic beat(input logic rw, input logic [31:0] a, input logic [31:0] w, input int k);
        bif.bus_rw    = rw;
        bif.bus_addr  = 8'(a >> (8 * k));
        bif.bus_wdata = 8'(w >> (8 * k));
    endtask

    // Called in the ADDR beat 0 cycle; ends in the frame_done cycle (chain) or one after.
    task automatic frame_body(input vec_t v, input bit chain, input string tag);
        bif.bus_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            beat((k == 0) ? v.rw : ~v.rw, v.addr, v.wdata, k);
            step();
        end
        chk({tag, "_we"},   mem_we,   v.exp_we);
        chk({tag, "_re"},   mem_re,   v.exp_re);
        chk({tag, "_addr"}, mem_addr, v.addr);
        if (v.rw) chk({tag, "_wdata"}, mem_wdata, v.wdata);
        chk({tag, "_oe_turn"}, bif.bus_rdata_oe, 1'b0);
        chk({tag, "_busy"}, busy, 1'b1);
        mem_rvalid = v.rv[0];
        mem_rdata  = v.rd0;
        step();
        chk({tag, "_req_1cyc"}, {mem_we, mem_re}, 2'b00);
        mem_rvalid = v.rv[1];
        mem_rdata  = v.rd1;
        step();
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("%s_rdata%0d", tag, b), bif.bus_rdata, 8'(v.exp_word >> (8 * b)));
            chk($sformatf("%s_oe%0d", tag, b), bif.bus_rdata_oe, v.exp_oe);
            mem_rvalid = v.rv[2];
            mem_rdata  = v.rd1;
            if (b == 3) bif.bus_start = chain;
            step();
        end
        mem_rvalid = 1'b0;
        chk({tag, "_done"},      frame_done,       1'b1);
        chk({tag, "_oe_end"},    bif.bus_rdata_oe, 1'b0);
        chk({tag, "_rdata_end"}, bif.bus_rdata,    8'h00);
        chk({tag, "_err"},       err_late,         v.exp_err);
        chk({tag, "_busy_end"},  busy,             chain);
        if (!chain) begin
            step();
            chk({tag, "_done_1cyc"}, frame_done, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        bif.bus_start = 1'b0;
        bif.bus_rw    = 1'b0;
        bif.bus_addr  = 8'h00;
        bif.bus_wdata = 8'h00;
        mem_rdata  = 32'h0;
        mem_rvalid = 1'b0;

        vt[0] = '{1'b1, 32'h12345678, 32'hDEADBEEF, 32'h0,        32'h0,        3'b000, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        vt[1] = '{1'b1, 32'h00001000, 32'h01020304, 32'h5555AAAA, 32'h5555AAAA, 3'b011, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        vt[2] = '{1'b0, 32'h00000040, 32'h0,        32'hCAFEF00D, 32'h0,        3'b001, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0};
        vt[3] = '{1'b0, 32'h00000044, 32'h0,        32'h0,        32'hA5A55A5A, 3'b010, 1'b0, 1'b1, 1'b1, 32'hA5A55A5A, 1'b0};
        vt[4] = '{1'b0, 32'h00000048, 32'h0,        32'h11223344, 32'h99999999, 3'b111, 1'b0, 1'b1, 1'b1, 32'h11223344, 1'b0};
        vt[5] = '{1'b0, 32'h0000004C, 32'h0,        32'h0,        32'h77777777, 3'b100, 1'b0, 1'b1, 1'b1, 32'h0,        1'b1};
        vt[6] = '{1'b0, 32'h00000050, 32'h0,        32'h13579BDF, 32'h0,        3'b001, 1'b0, 1'b1, 1'b1, 32'h13579BDF, 1'b1};
        vt[7] = '{1'b1, 32'hFFFFFFFC, 32'h0F1E2D3C, 32'h0,        32'h0,        3'b000, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1};

        step();
        step();
        chk("rst_mem_addr",  mem_addr,  32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_req",       {mem_we, mem_re}, 2'b00);
        chk("rst_bus",       {bif.bus_rdata_oe, bif.bus_rdata}, 9'h000);
        chk("rst_status",    {busy, frame_done, err_late}, 3'b000);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            bif.bus_start = 1'b1;
            step();
            frame_body(vt[i], 1'b0, $sformatf("v%0d", i));
        end

        // Restart during ADDR beat 2: no request from the aborted frame.
        bif.bus_start = 1'b1;
        step();
        bif.bus_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            beat(1'b1, 32'hAAAAAAAA, 32'hBBBBBBBB, k);
            if (k == 2) bif.bus_start = 1'b1;
            step();
            chk($sformatf("abort_addr_req%0d", k), {mem_we, mem_re}, 2'b00);
        end
        chk("abort_addr_busy", busy, 1'b1);
        vx = '{1'b0, 32'h00C0FFEE, 32'h0, 32'hCAFEF00D, 32'h0, 3'b001, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 1'b1};
        frame_body(vx, 1'b0, "abort_new");

        // Back-to-back: bus_start on DATA beat 3.
        bus_b2b: begin
            bif.bus_start = 1'b1;
            step();
            vx = '{1'b0, 32'h00000060, 32'h0, 32'h0, 32'h89ABCDEF, 3'b010, 1'b0, 1'b1, 1'b1, 32'h89ABCDEF, 1'b1};
            frame_body(vx, 1'b1, "b2b0");
            vx = '{1'b1, 32'h00000064, 32'h76543210, 32'h0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1};
            frame_body(vx, 1'b0, "b2b1");
        end

        // Restart during DATA beat 1: oe drops, no frame_done.
        bif.bus_start = 1'b1;
        step();
        bif.bus_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            beat(1'b0, 32'h00000070, 32'h0, k);
            step();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BADBEEF;
        step();
        mem_rvalid = 1'b0;
        step();
        chk("abort_data_b0", bif.bus_rdata, 8'hEF);
        step();
        chk("abort_data_b1", {bif.bus_rdata_oe, bif.bus_rdata}, {1'b1, 8'hBE});
        bif.bus_start = 1'b1;
        step();
        chk("abort_data_oe",   {bif.bus_rdata_oe, bif.bus_rdata}, 9'h000);
        chk("abort_data_done", frame_done, 1'b0);
        vx = '{1'b0, 32'h00000074, 32'h0, 32'h2468ACE0, 32'h0, 3'b001, 1'b0, 1'b1, 1'b1, 32'h2468ACE0, 1'b1};
        frame_body(vx, 1'b0, "after_abort");

        // Reset mid-DATA clears everything, including the sticky error.
        bif.bus_start = 1'b1;
        step();
        bif.bus_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            beat(1'b1, 32'h00000080, 32'h55667788, k);
            step();
        end
        step();
        step();
        step();
        chk("pre_rst_err", err_late, 1'b1);
        rst = 1'b1;
        step();
        chk("mid_rst_mem",    {mem_addr, mem_wdata}, 64'h0);
        chk("mid_rst_req",    {mem_we, mem_re}, 2'b00);
        chk("mid_rst_bus",    {bif.bus_rdata_oe, bif.bus_rdata}, 9'h000);
        chk("mid_rst_status", {busy, frame_done, err_late}, 3'b000);
        rst = 1'b0;
        step();
        chk("post_rst_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
